// File: rtl/span_cme_sequencer_pkg.sv
// Shared types and default constants for the span_cme sequencer slice.
package span_pkg;

  typedef enum logic [2:0] {
    LOAD = 3'd0,
    WAIT = 3'd1,
    RD   = 3'd2,
    CAPT = 3'd3,
    HOLD = 3'd4
  } seq_state_t;

  localparam int SPAN_NUM_REGS      = 29;
  localparam int SPAN_RESULT_OFFSET = 29;
  localparam int SPAN_OFS_W         = 5;

endpackage

// File: rtl/span_cme_sequencer_wait_timer.sv
// Loadable 16-bit down-counter; done flags the final cycle of the compute window.
module span_wait_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  output logic        done
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != 16'd0)) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign done = (cnt_q == 16'd1);

endmodule

// File: rtl/span_cme_sequencer.sv
// Streams a parameter frame into span_cme, waits out the compute window,
// then reads back the margin result and holds it on a valid/ready output.
module span_cme_sequencer
  import span_pkg::*;
#(
  parameter int NUM_REGS       = SPAN_NUM_REGS,
  parameter int COMPUTE_CYCLES = 64,
  parameter int RESULT_OFFSET  = SPAN_RESULT_OFFSET
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [15:0]           writeData,
  output logic [SPAN_OFS_W-1:0] offset,
  output logic                  write,
  output logic                  read,
  output logic                  chipselect,
  input  logic [15:0]           readData,
  input  logic [15:0]           PriceScanRange,
  output logic [15:0]           res_margin,
  output logic [15:0]           res_scan,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  frame_err,
  output logic [15:0]           frame_cnt,
  output seq_state_t            dbg_state
);

  localparam logic [SPAN_OFS_W-1:0] LAST_IDX = SPAN_OFS_W'(NUM_REGS - 1);
  localparam logic [SPAN_OFS_W-1:0] RES_OFS  = SPAN_OFS_W'(RESULT_OFFSET);
  localparam logic [15:0]           CYC_INIT = 16'(COMPUTE_CYCLES);

  seq_state_t            state_q, state_d;
  logic [SPAN_OFS_W-1:0] idx_q, idx_d;
  logic [SPAN_OFS_W-1:0] ofs_q, ofs_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  read_q, read_d;
  logic                  cs_q, cs_d;
  logic [15:0]           margin_q, margin_d;
  logic [15:0]           scan_q, scan_d;
  logic                  ferr_q, ferr_d;
  logic [15:0]           fcnt_q, fcnt_d;
  logic                  timer_load, timer_done;
  logic                  in_hs;

  // Valid/ready: a word or result transfers on any rising edge where both
  // valid and ready are high; ready depends only on state (and reset).
  assign in_ready = (state_q == LOAD) && !reset;
  assign in_hs    = in_valid && in_ready;

  span_wait_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (CYC_INIT),
    .en       (state_q == WAIT),
    .done     (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ofs_d      = ofs_q;
    wdata_d    = wdata_q;
    write_d    = 1'b0;
    read_d     = 1'b0;
    cs_d       = 1'b0;
    margin_d   = margin_q;
    scan_d     = scan_q;
    ferr_d     = 1'b0;
    fcnt_d     = fcnt_q;
    timer_load = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_hs) begin
          wdata_d = in_data;
          ofs_d   = idx_q;
          write_d = 1'b1;
          cs_d    = 1'b1;
          if (idx_q == LAST_IDX) begin
            // The final slot always completes the frame; a missing in_last is flagged.
            idx_d      = '0;
            ferr_d     = !in_last;
            timer_load = 1'b1;
            state_d    = WAIT;
          end else if (in_last) begin
            idx_d  = '0;
            ferr_d = 1'b1;
          end else begin
            idx_d = idx_q + SPAN_OFS_W'(1);
          end
        end
      end
      WAIT: begin
        if (timer_done) begin
          read_d  = 1'b1;
          cs_d    = 1'b1;
          ofs_d   = RES_OFS;
          state_d = RD;
        end
      end
      RD: state_d = CAPT;
      CAPT: begin
        margin_d = readData;
        scan_d   = PriceScanRange;
        fcnt_d   = fcnt_q + 16'd1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (res_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      idx_q    <= '0;
      ofs_q    <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
      cs_q     <= 1'b0;
      margin_q <= '0;
      scan_q   <= '0;
      ferr_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ofs_q    <= ofs_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      read_q   <= read_d;
      cs_q     <= cs_d;
      margin_q <= margin_d;
      scan_q   <= scan_d;
      ferr_q   <= ferr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign writeData  = wdata_q;
  assign offset     = ofs_q;
  assign write      = write_q;
  assign read       = read_q;
  assign chipselect = cs_q;
  assign res_margin = margin_q;
  assign res_scan   = scan_q;
  assign res_valid  = (state_q == HOLD);
  assign frame_err  = ferr_q;
  assign frame_cnt  = fcnt_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/span_cme_sequencer.md
# span_cme_sequencer

Bus-master controller that sequences one `span_cme` margin engine. It accepts a portfolio frame of NUM_REGS 16-bit parameter words on a valid/ready stream and writes them to `span_cme` offsets 0..NUM_REGS-1 in order. It then waits a fixed compute window, reads back the result register, and presents the margin and price-scan-range results on a valid/ready output. It replaces the hand-driven register writes used today, and sits between the host DMA stream and `span_cme`.

## Interface
- NUM_REGS, 29, parameter words per frame; span_cme offsets 0..NUM_REGS-1.
- COMPUTE_CYCLES, 64, idle cycles between the last write and the result read (legal range 1..65535).
- RESULT_OFFSET, 29, span_cme offset read for the margin result.
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_data  in  16  parameter word (two's complement where signed).
- in_valid  in  1  in_data valid.
- in_last  in  1  marks the final word of a frame.
- in_ready  out  1  sequencer accepts the word this cycle.
- writeData  out  16  span_cme write data.
- offset  out  5  span_cme register offset.
- write  out  1  span_cme write strobe.
- read  out  1  span_cme read strobe.
- chipselect  out  1  span_cme select.
- readData  in  16  span_cme read data, valid the cycle after read.
- PriceScanRange  in  16  span_cme scan-range result.
- res_margin  out  16  captured readData.
- res_scan  out  16  captured PriceScanRange.
- res_valid  out  1  results valid; held until res_ready.
- res_ready  in  1  downstream accepts the results.
- frame_err  out  1  one-cycle pulse on a framing error.
- frame_cnt  out  16  completed frames; wraps at 65535 to 0.

## Operation
- FSM states: LOAD, WAIT, RD, CAPT, HOLD. Reset enters LOAD.
- LOAD:
  - in_ready=1; word index idx starts at 0.
  - On handshake, next cycle registers writeData=in_data, offset=idx, write=1, chipselect=1; idx++.
  - write/chipselect are single-cycle pulses per accepted word; both are 0 when there is no handshake.
- in_last at idx<NUM_REGS-1: frame abandoned; frame_err pulses; idx=0; state stays LOAD. Words already written are not retracted.
- Word idx=NUM_REGS-1 without in_last: it is still written; frame_err pulses; the frame is treated as complete.
- After word NUM_REGS-1 is accepted, go to WAIT and load the down-counter with COMPUTE_CYCLES.
- WAIT: in_ready=0; the counter decrements each cycle; when it reaches 1, go to RD.
- RD: for one cycle, read=1, chipselect=1, offset=RESULT_OFFSET, write=0.
- CAPT: res_margin<=readData and res_scan<=PriceScanRange; frame_cnt++; go to HOLD.
- HOLD: res_valid=1; res_margin and res_scan are stable. On res_ready, res_valid drops next cycle and the state returns to LOAD with idx=0.
- res_ready outside HOLD is ignored. in_valid outside LOAD is ignored, with no data loss, because in_ready=0.

## Timing
- Output reset values:
  - in_ready=0 during the reset cycle, 1 on the first cycle after reset.
  - writeData=0, offset=0, write=0, read=0, chipselect=0.
  - res_margin=0, res_scan=0, res_valid=0, frame_err=0, frame_cnt=0.
- Write latency: 1 cycle from input handshake to write strobe. Back-to-back handshakes give back-to-back writes.
- Frame latency: the write of word NUM_REGS-1 is followed by COMPUTE_CYCLES cycles in WAIT, then RD, then CAPT, then res_valid on the next cycle.
- read and write are never asserted in the same cycle.
- Reset asserted mid-frame or in WAIT/HOLD:
  - All state returns to reset values on the next edge.
  - Any pending result is discarded.
  - frame_cnt clears.
- in_ready is a function of state only; it never depends combinationally on in_valid.

## Structure
- Package `span_pkg` holds:
  - the `seq_state_t` enum (LOAD, WAIT, RD, CAPT, HOLD);
  - default constants SPAN_NUM_REGS=29 and SPAN_RESULT_OFFSET=29;
  - the offset width constant SPAN_OFS_W=5.
- One sub-module, `span_wait_timer`: a loadable 16-bit down-counter with a `done` output. All other logic is inline.

## Test plan
- Nominal frame:
  - Stimulus: stream 300, 30, 30, -10, -10, -20, 5, 0, 0, 3, 1, 5, 1, 3, 5, 0, 0, 2, 4, 6, 50, 60, 70, 80, 90, 100, 100, 110, 120 with in_last on the 29th word; stub drives readData=16'hBEEF and PriceScanRange=16'd300.
  - Required: 29 writes at offsets 0..28 with matching data; read at offset 29 exactly 64 cycles after the last write; res_margin=BEEF, res_scan=300; frame_cnt=1.
- Backpressure:
  - Stimulus: hold res_ready=0 for 20 cycles; drive in_valid=1 throughout.
  - Required: res_valid and both results stable; in_ready=0; no writes until res_ready.
- Early in_last:
  - Stimulus: assert in_last on word 5.
  - Required: frame_err pulses once; the next word is written at offset 0; frame_cnt unchanged.
- Missing in_last:
  - Stimulus: send 29 words with in_last=0.
  - Required: frame_err pulses after word 28; the frame completes; frame_cnt increments.
- Reset during WAIT:
  - Required: all outputs return to reset values; a following nominal frame completes correctly.
- Gapped input:
  - Stimulus: toggle in_valid every other cycle.
  - Required: writes occur only on handshake cycles, with offsets contiguous 0..28.
